// File: rtl/svc_rv_bpred_btb.sv
// svc_rv_bpred_btb: direct-mapped branch target buffer with 2-bit saturating direction counters
module svc_rv_bpred_btb #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 4,
    parameter int TAG_W = XLEN - IDX_W - 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] f_pc,
    input  logic            f_valid,
    input  logic            f_stall,
    input  logic            f_flush,
    output logic            pred_valid,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);
    localparam int N = 1 << IDX_W;

    logic [N-1:0]       valid;
    logic [N-1:0][1:0]  cnt;
    logic [TAG_W-1:0]   tags    [N];
    logic [XLEN-1:0]    targets [N];
    logic [IDX_W-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0]   f_tag, u_tag;
    logic               l_hit, u_hit;
    logic [1:0]         u_cnt;
    logic               unused_pc_lsb;

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[XLEN-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[XLEN-1:IDX_W+2];
    assign l_hit = valid[f_idx] && (tags[f_idx] == f_tag);
    assign u_hit = valid[u_idx] && (tags[u_idx] == u_tag);
    assign u_cnt = cnt[u_idx];
    assign unused_pc_lsb = ^{f_pc[1:0], upd_pc[1:0]};

    // Valid bits and direction counters, trained by resolved outcomes
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid <= '0;
            cnt   <= {N{2'b01}};
        end else if (upd_valid) begin
            if (u_hit)
                cnt[u_idx] <= upd_taken ? ((u_cnt == 2'd3) ? 2'd3 : u_cnt + 2'd1)
                                        : ((u_cnt == 2'd0) ? 2'd0 : u_cnt - 2'd1);
            else if (upd_taken) begin
                valid[u_idx] <= 1'b1;
                cnt[u_idx]   <= 2'b10;
            end
        end

    // Tag/target arrays: every taken update refreshes a hit or allocates over a miss
    always_ff @(posedge clk)
        if (upd_valid && upd_taken) begin
            tags[u_idx]    <= u_tag;
            targets[u_idx] <= upd_target;
        end

    // Prediction registers: flush beats stall beats a new lookup
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (f_flush) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (!f_stall) begin
            pred_valid  <= f_valid;
            pred_hit    <= f_valid && l_hit;
            pred_taken  <= f_valid && l_hit && cnt[f_idx][1];
            pred_target <= (f_valid && l_hit) ? targets[f_idx] : '0;
        end
endmodule

// File: doc/svc_rv_bpred_btb.md
Name: svc_rv_bpred_btb

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Feeds the fetch stage of the pipelined RV core when branch prediction is enabled.
- Indexed by the fetch PC in the same cycle the BRAM instruction read is issued. Prediction is registered, so it arrives aligned with the BRAM instruction one cycle later.
- Trained by the execute stage with resolved branch/jump outcomes.

Parameters:
- XLEN, 32, PC/target width.
- IDX_W, 4, index bits; 2**IDX_W entries. Index = pc[IDX_W+1:2].
- TAG_W, XLEN-IDX_W-2, tag bits = pc[XLEN-1:IDX_W+2].

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- f_pc  input  XLEN  fetch PC presented with the imem read
- f_valid  input  1  f_pc is a real fetch
- f_stall  input  1  hold prediction registers
- f_flush  input  1  kill the in-flight prediction
- pred_valid  output  1  prediction registers hold a lookup result
- pred_hit  output  1  tag match on a valid entry
- pred_taken  output  1  pred_hit and counter MSB set
- pred_target  output  XLEN  stored target (0 when not hit)
- upd_valid  input  1  execute-stage resolved control-flow instruction
- upd_pc  input  XLEN  PC of resolved instruction
- upd_taken  input  1  actual direction
- upd_target  input  XLEN  actual target

Behaviour:
- Reset (async, rst_n=0):
  - all valid bits = 0; all counters = 2'b01 (weakly not-taken).
  - pred_valid = pred_hit = pred_taken = 0; pred_target = 0.
  - Tag/target arrays are not reset.
- Lookup:
  - Combinational read of entry[f_pc index] against the pre-update state; hit = valid && tag==f_pc tag.
  - Result registered at the clock edge; latency 1 cycle.
- Output register priority, highest first:
  - f_flush=1: pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0.
  - else f_stall=1: all four hold.
  - else: pred_valid=f_valid; pred_hit/pred_taken/pred_target from the lookup, all forced to 0 when f_valid=0 or on miss.
- Update (at clock edge when upd_valid=1), on hit at the upd_pc index:
  - counter +1 saturating at 3 if taken, -1 saturating at 0 if not taken.
  - target overwritten with upd_target when taken.
- Update on miss:
  - taken: allocate/replace; valid=1, tag, target=upd_target, counter=2'b10 (weakly taken).
  - not taken: no change. No allocation on not-taken misses.
- Simultaneous lookup and update to the same index in one cycle: lookup returns the old entry (read-before-write, no bypass). The update becomes visible to lookups from the next cycle.
- Aliasing: different tags sharing an index evict each other only on a taken allocation.
- pc[1:0] are ignored.
- Reset asserted mid-operation clears valid bits and outputs immediately, independent of clk.
- Fully synchronous array writes. Counters and valid bits are flops; tag/target arrays may be inferred as distributed RAM with asynchronous read.

Test Plan:
- Reset then f_pc=0x100, f_valid=1 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0.
- upd_valid with pc=0x100, taken=1, target=0x80; then lookup 0x100 -> pred_hit=1, pred_taken=1, pred_target=0x80.
- Counter saturation at 0x100:
  - three further taken updates (counter 3), then two not-taken -> counter 1, pred_taken=0, pred_hit=1.
  - one more taken -> pred_taken=1.
- Aliasing and same-index ordering, IDX_W=4:
  - taken update at 0x140 (index 0, different tag from 0x100) evicts it; lookup 0x100 -> pred_hit=0.
  - lookup 0x140 in the same cycle as its allocating update -> miss; next cycle -> hit.
- Stall and flush:
  - lookup 0x100 hit, then f_stall=1 for 3 cycles with f_pc=0x200 -> outputs hold 0x80/taken.
  - f_flush=1 -> pred_valid=0 next cycle, even with f_stall=1.
- Not-taken update at unseen pc=0x300 -> no allocation; lookup 0x300 -> pred_hit=0.
- Async rst_n pulse mid-stream -> all outputs 0 without a clock edge; lookup 0x100 afterwards misses.
